palette_update_sched: RTL

- Schedules run-time updates of the 64-entry RGB palette RAMs read by the VGA colour path.
- Requesters push (index, colour) writes through a valid/ready port. Writes are buffered in a small FIFO and committed to the palette write port only inside blanking windows, so a visible pixel never sees a half-updated palette.
- Per-entry "frame-sync" writes are held until vertical blanking, so whole-palette swaps land atomically between frames.

---
 rtl/vga_timing_pkg.sv | 38 +++
 rtl/palette_req_fifo.sv | 74 +++++++
 rtl/palette_update_sched.sv | 131 +++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing and palette definitions.
//
// Holds the default 1280x480 timing constants, the RGB18 field layout, the
// palette index width, the buffered palette request record and the state
// encoding of the palette update scheduler.
package vga_timing_pkg;

  localparam int unsigned DEF_H_DISPLAY = 1280;
  localparam int unsigned DEF_H_TOTAL   = 1600;
  localparam int unsigned DEF_V_DISPLAY = 480;
  localparam int unsigned DEF_V_TOTAL   = 525;

  localparam int unsigned H_CNT_W = 11;
  localparam int unsigned V_CNT_W = 10;

  // RGB18 word layout: {r[5:0], g[5:0], b[5:0]}.
  localparam int unsigned RGB_W  = 18;
  localparam int unsigned R_LSB  = 12;
  localparam int unsigned G_LSB  = 6;
  localparam int unsigned B_LSB  = 0;
  localparam int unsigned CH_W   = 6;

  localparam int unsigned PAL_IDX_W = 6;

  // One buffered palette write.
  typedef struct packed {
    logic                 fsync;
    logic [PAL_IDX_W-1:0] index;
    logic [RGB_W-1:0]     rgb;
  } pal_req_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_COMMIT = 2'd2
  } sched_state_e;

endpackage

// File: rtl/palette_req_fifo.sv
// Synchronous FIFO of pending palette writes.
//
// Ports:
//   clk50, rst_n   clock, asynchronous active-low reset
//   push, push_req write one request (caller guarantees not full)
//   pop            drop the head entry (caller guarantees not empty)
//   flush          synchronous clear; overrides push and pop
//   head           current head entry (valid while count != 0)
//   count          occupancy, 0..DEPTH
module palette_req_fifo
  import vga_timing_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk50,
  input  logic          rst_n,
  input  logic          push,
  input  pal_req_t      push_req,
  input  logic          pop,
  input  logic          flush,
  output pal_req_t      head,
  output logic [CW-1:0] count
);

  pal_req_t      mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking (<=) so all flops sample pre-edge values.
  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers/count decide what is valid.
  always_ff @(posedge clk50) begin
    if (push && !flush) mem_q[wr_ptr_q] <= push_req;
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/palette_update_sched.sv
// Palette update scheduler.
//
// Buffers (index, colour) writes and commits them to the palette RAM write
// port only inside blanking, one per clock, strictly in order. Frame-sync
// entries wait for vertical blanking and block everything behind them.
//
// Ports:
//   clk50, rst_n            clock, asynchronous active-low reset
//   h_count, v_count        current raster position from the timing generator
//   wr_valid/wr_ready       request handshake; wr_index, wr_rgb, wr_fsync payload
//   flush                   synchronous discard of all pending requests
//   pal_we/pal_addr/pal_wdata registered palette write port
//   pending                 FIFO occupancy
//   frame_tick              registered pulse on the first vblank clock
module palette_update_sched
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_DISPLAY = DEF_H_DISPLAY,
  parameter int unsigned H_TOTAL   = DEF_H_TOTAL,
  parameter int unsigned V_DISPLAY = DEF_V_DISPLAY,
  parameter int unsigned V_TOTAL   = DEF_V_TOTAL,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned GUARD     = 4,
  localparam int unsigned CW = $clog2(DEPTH) + 1
) (
  input  logic                 clk50,
  input  logic                 rst_n,
  input  logic [H_CNT_W-1:0]   h_count,
  input  logic [V_CNT_W-1:0]   v_count,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [PAL_IDX_W-1:0] wr_index,
  input  logic [RGB_W-1:0]     wr_rgb,
  input  logic                 wr_fsync,
  input  logic                 flush,
  output logic                 pal_we,
  output logic [PAL_IDX_W-1:0] pal_addr,
  output logic [RGB_W-1:0]     pal_wdata,
  output logic [CW-1:0]        pending,
  output logic                 frame_tick
);

  localparam logic [H_CNT_W-1:0] H_DISP_C   = H_CNT_W'(H_DISPLAY);
  localparam logic [H_CNT_W-1:0] H_GUARD_C  = H_CNT_W'(H_TOTAL - GUARD);
  localparam logic [V_CNT_W-1:0] V_DISP_C   = V_CNT_W'(V_DISPLAY);
  localparam logic [V_CNT_W-1:0] V_LAST_C   = V_CNT_W'(V_TOTAL - 1);
  localparam logic [CW-1:0]      FULL_C     = CW'(DEPTH);

  pal_req_t      head;
  logic [CW-1:0] count;
  logic          push, pop;
  logic          vblank, hwin, vwin, eligible;
  logic [CW-1:0] count_next;

  sched_state_e         state_q, state_d;
  logic                 pal_we_q, pal_we_d;
  logic [PAL_IDX_W-1:0] pal_addr_q, pal_addr_d;
  logic [RGB_W-1:0]     pal_wdata_q, pal_wdata_d;
  logic                 frame_tick_q, frame_tick_d;

  palette_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk50    (clk50),
    .rst_n    (rst_n),
    .push     (push),
    .push_req ('{fsync: wr_fsync, index: wr_index, rgb: wr_rgb}),
    .pop      (pop),
    .flush    (flush),
    .head     (head),
    .count    (count)
  );

  assign wr_ready = (count < FULL_C) && !flush;
  assign push     = wr_valid && wr_ready;

  // Commit windows. Commits stop GUARD clocks before end of line so the last
  // write lands before the next visible pixel; on the final vblank line the
  // same guard protects the first visible line of the next frame.
  assign vblank   = v_count >= V_DISP_C;
  assign hwin     = (h_count >= H_DISP_C) && (h_count < H_GUARD_C) && !vblank;
  assign vwin     = vblank && !((v_count == V_LAST_C) && (h_count >= H_GUARD_C));
  assign eligible = vwin || (hwin && !head.fsync);

  // A push into an empty FIFO cannot pop on the same edge because count is 0.
  assign pop = (count != '0) && eligible && !flush;

  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + CW'(1);
    else if (pop && !push) count_next = count - CW'(1);

    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (push) state_d = ST_WAIT;
      ST_WAIT:   if (pop)  state_d = (count_next == '0) ? ST_IDLE : ST_COMMIT;
      ST_COMMIT: begin
        if (count_next == '0) state_d = ST_IDLE;
        else if (!pop)        state_d = ST_WAIT;
      end
      default:   state_d = ST_IDLE;
    endcase
    if (flush) state_d = ST_IDLE;

    pal_we_d     = pop;
    pal_addr_d   = pop ? head.index : pal_addr_q;
    pal_wdata_d  = pop ? head.rgb   : pal_wdata_q;
    frame_tick_d = (h_count == '0) && (v_count == V_DISP_C);
  end

  always_ff @(posedge clk50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pal_we_q     <= 1'b0;
      pal_addr_q   <= '0;
      pal_wdata_q  <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pal_we_q     <= pal_we_d;
      pal_addr_q   <= pal_addr_d;
      pal_wdata_q  <= pal_wdata_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign pal_we     = pal_we_q;
  assign pal_addr   = pal_addr_q;
  assign pal_wdata  = pal_wdata_q;
  assign pending    = count;
  assign frame_tick = frame_tick_q;

endmodule
